ws2811_strip_scheduler: RTL and testbench

Sequences pixel data from the pixel FIFO into the WS2811 bit encoder, one strip at a time. Per strip it streams LEDS_PER_STRIP×3 bytes MSB-first, inserts the reset/latch gap, then advances the strip select and wraps across NUM_STRIPS to form a frame. It sits between the pixel FIFO and the PWM bit encoder, and it owns the strip demux select.

---
 rtl/ws2811_pkg.sv | 26 ++
 rtl/ws2811_strip_scheduler_if.sv | 29 ++
 rtl/ws2811_gap_timer.sv | 57 +++++
 rtl/ws2811_strip_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ws2811_strip_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2811_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : ws2811_pkg                                             |
// | Description : Shared scheduler state encoding, byte geometry and the |
// |               default strip geometry for the WS2811 strip scheduler. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package ws2811_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam int BYTES_PER_LED = 3;

  localparam int DEFAULT_RESET_CYCLES   = 2500;
  localparam int DEFAULT_LEDS_PER_STRIP = 50;
  localparam int DEFAULT_NUM_STRIPS     = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_DATA = 3'd2,
    SHIFT     = 3'd3,
    GAP       = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ws2811_strip_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : ws2811_strip_scheduler_if                              |
// | Description : Pixel FIFO read port and bit-encoder handshake seen by |
// |               the strip scheduler. master = scheduler side,          |
// |               slave = FIFO / encoder side.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface ws2811_strip_scheduler_if;

  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       bit_data;
  logic       bit_valid;
  logic       bit_ready;

  modport master (
    input  fifo_data, fifo_empty, bit_ready,
    output fifo_rd, bit_data, bit_valid
  );

  modport slave (
    output fifo_data, fifo_empty, bit_ready,
    input  fifo_rd, bit_data, bit_valid
  );

endinterface
`default_nettype wire

// File: rtl/ws2811_gap_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ws2811_gap_timer                                       |
// | Description : Latch-gap down-counter. A load pulse arms it; expire_o |
// |               pulses for one cycle in the RESET_CYCLES-th cycle      |
// |               after the load, then the timer goes quiet.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ws2811_gap_timer
  import ws2811_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Next count: load arms the timer, then count down to zero and disarm.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = CNT_LOAD;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire_o = active_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ws2811_strip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ws2811_strip_scheduler                                 |
// | Description : Pulls pixel bytes from the FIFO, serialises them MSB-  |
// |               first into the WS2811 bit encoder strip by strip,      |
// |               inserts the latch gap after every strip and drives the |
// |               strip demux select.                                    |
// | Options     : WS_UNDERRUN_BLANK_EN - when defined, an empty FIFO in  |
// |               FETCH substitutes a 0x00 byte instead of stalling.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ws2811_strip_scheduler
  import ws2811_pkg::*;
#(
  parameter  int RESET_CYCLES   = DEFAULT_RESET_CYCLES,
  parameter  int LEDS_PER_STRIP = DEFAULT_LEDS_PER_STRIP,
  parameter  int NUM_STRIPS     = DEFAULT_NUM_STRIPS,
  localparam int SEL_W          = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  ws2811_strip_scheduler_if.master   bus,
  output logic [SEL_W-1:0]           strip_sel,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       underrun
);

  localparam int BYTES_PER_STRIP = LEDS_PER_STRIP * BYTES_PER_LED;
  localparam int BYTE_W          = $clog2(BYTES_PER_STRIP + 1);
  localparam int BIT_W           = $clog2(BITS_PER_BYTE);

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_STRIP - 1);
  localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_STRIPS - 1);
  localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);

  state_t                     state_q, state_d;
  logic [BITS_PER_BYTE-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [SEL_W-1:0]           strip_sel_q, strip_sel_d;
  logic                       underrun_q, underrun_d;
  logic                       gap_load;
  logic                       gap_expire;

  ws2811_gap_timer #(
    .RESET_CYCLES (RESET_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (gap_load),
    .expire_o (gap_expire)
  );

  // Scheduler next-state, datapath next values and handshake outputs.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    strip_sel_d   = strip_sel_q;
    underrun_d    = underrun_q;
    gap_load      = 1'b0;
    frame_done    = 1'b0;
    bus.fifo_rd   = 1'b0;
    bus.bit_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d     = FETCH;
          strip_sel_d = '0;
          byte_cnt_d  = '0;
        end
      end

      FETCH: begin
        if (!bus.fifo_empty) begin
          bus.fifo_rd = 1'b1;
          state_d     = WAIT_DATA;
        end else begin
          underrun_d = 1'b1;
`ifdef WS_UNDERRUN_BLANK_EN
          // Send a black byte in place of the missing one so the strip
          // keeps its timing; the FIFO is not touched.
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
`endif
        end
      end

      WAIT_DATA: begin
        shreg_d   = bus.fifo_data;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        bus.bit_valid = 1'b1;
        if (bus.bit_ready) begin
          shreg_d = {shreg_q[BITS_PER_BYTE-2:0], 1'b0};
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d  = '0;
            byte_cnt_d = byte_cnt_q + BYTE_ONE;
            if (byte_cnt_q == BYTE_LAST) begin
              // Arm the gap timer now so it starts counting next cycle.
              gap_load = 1'b1;
              state_d  = GAP;
            end else begin
              state_d = FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end

      GAP: begin
        if (gap_expire) begin
          byte_cnt_d = '0;
          if (strip_sel_q == SEL_LAST) begin
            strip_sel_d = '0;
            frame_done  = 1'b1;
            state_d     = run ? FETCH : IDLE;
          end else begin
            strip_sel_d = strip_sel_q + SEL_ONE;
            state_d     = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift register, counters and sticky underrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      strip_sel_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      strip_sel_q <= strip_sel_d;
      underrun_q  <= underrun_d;
    end
  end

  // The line is held low whenever no bit is being offered.
  assign bus.bit_data = (state_q == SHIFT) ? shreg_q[BITS_PER_BYTE-1] : 1'b0;
  assign strip_sel    = strip_sel_q;
  assign busy         = (state_q != IDLE);
  assign underrun     = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2811_strip_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ws2811_strip_scheduler                              |
// | Description : Scoreboard bench for ws2811_strip_scheduler with a     |
// |               2-strip, 2-LED, 10-cycle-gap geometry.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ws2811_strip_scheduler;

  localparam int R   = 10;
  localparam int L   = 2;
  localparam int N   = 2;
  localparam int BPS = L * 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [0:0] strip_sel;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  ws2811_strip_scheduler_if bus_if ();

  ws2811_strip_scheduler #(
    .RESET_CYCLES   (R),
    .LEDS_PER_STRIP (L),
    .NUM_STRIPS     (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus_if),
    .strip_sel  (strip_sel),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_count = 0;
  logic       force_empty = 1'b0;

  assign bus_if.fifo_empty = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (bus_if.fifo_rd) begin
      bus_if.fifo_data <= mem[rd_ptr[7:0]];
      rd_ptr           <= rd_ptr + 1;
      rd_count         <= rd_count + 1;
    end
  end

  // ---------------- encoder ready pattern ----------------
  logic bp_en = 1'b0;
  int   phase = 0;

  initial begin
    bus_if.bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus_if.bit_ready = (phase != 0);
        phase = (phase + 1) % 3;
      end else begin
        bus_if.bit_ready = 1'b1;
        phase = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q [$];   // {bit, strip}
  int errors = 0;
  int checks = 0;
  int hs_count = 0;
  int fd_count = 0;
  int last_hs = 0;

  logic [7:0] pat [12] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0,
                           8'h81, 8'h7E, 8'h12, 8'h34, 8'h56, 8'h78};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fifo_push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic exp_push(input logic [7:0] b, input logic s);
    for (int i = 7; i >= 0; i--) exp_q.push_back({b[i], s});
  endtask

  task automatic load_frame(input logic [7:0] seed);
    for (int i = 0; i < 2 * BPS; i++) begin
      fifo_push(pat[i] ^ seed);
      exp_push(pat[i] ^ seed, (i >= BPS));
    end
  endtask

  // Monitor: compares every accepted bit and watches gap/hold timing.
  initial begin
    logic       prev_stall = 1'b0;
    logic       prev_data  = 1'b0;
    logic       prev_rd    = 1'b0;
    logic [0:0] prev_sel   = 1'b0;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
        prev_sel   = strip_sel;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", bus_if.bit_valid, 1'b1);
        check("hold_data", bus_if.bit_data, prev_data);
      end
      prev_stall = bus_if.bit_valid && !bus_if.bit_ready;
      prev_data  = bus_if.bit_data;
      if (bus_if.fifo_rd && prev_rd) check("fifo_rd_back_to_back", 1, 0);
      prev_rd = bus_if.fifo_rd;
      if (bus_if.bit_valid && bus_if.bit_ready) begin
        hs_count++;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bit%0d", hs_count), {bus_if.bit_data, strip_sel}, e);
        end
      end
      if (frame_done) begin
        fd_count++;
        check("gap_len_frame", cyc - last_hs, R);
      end
      if (strip_sel != prev_sel) check("gap_len_strip", cyc - last_hs, R + 1);
      prev_sel = strip_sel;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd"},    bus_if.fifo_rd, 0);
    check({tag, "_bit_data"},   bus_if.bit_data, 0);
    check({tag, "_bit_valid"},  bus_if.bit_valid, 0);
    check({tag, "_strip_sel"},  strip_sel, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_underrun"},   underrun, 0);
  endtask

  // Called just after a negedge; raises run and checks the start latency.
  task automatic start_run();
    #1 run = 1'b1;
    @(negedge clk);
    check("start_fifo_rd", bus_if.fifo_rd, 1);
    check("start_busy", busy, 1);
    check("start_sel", strip_sel, 0);
    @(negedge clk);
    check("wait_no_valid", {bus_if.bit_valid, bus_if.fifo_rd}, 2'b00);
    @(negedge clk);
    check("first_valid", bus_if.bit_valid, 1);
  endtask

  task automatic wait_frame_done();
    int n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_timeout", (n >= 3000), 0);
    check("all_bits_sent", exp_q.size(), 0);
  endtask

  task automatic finish_frame(input int fd_expected);
    #1 run = 1'b0;
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("frame_count", fd_count, fd_expected);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    int rd_seen;
    int valid_seen;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single frame, run held until the frame boundary
    load_frame(8'h00);
    start_run();
    wait_frame_done();
    finish_frame(1);

    // Backpressure
    bp_en = 1'b1;
    load_frame(8'h5A);
    start_run();
    wait_frame_done();
    finish_frame(2);
    bp_en = 1'b0;
    check("no_underrun_yet", underrun, 0);

    // FIFO empty for 20 cycles after the third byte read
    base = rd_count;
`ifdef WS_UNDERRUN_BLANK_EN
    for (int i = 0; i < 2 * BPS; i++) fifo_push(pat[i] ^ 8'h66);
    for (int i = 0; i < 3; i++) exp_push(pat[i] ^ 8'h66, 1'b0);
    exp_push(8'h00, 1'b0);
    exp_push(8'h00, 1'b0);
    exp_push(pat[3] ^ 8'h66, 1'b0);
    for (int i = 4; i < 10; i++) exp_push(pat[i] ^ 8'h66, 1'b1);
`else
    load_frame(8'h66);
`endif
    start_run();
    n = 0;
    while (rd_count < base + 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("third_read_timeout", (n >= 500), 0);
    #1 force_empty = 1'b1;
    rd_seen = 0;
    valid_seen = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (bus_if.fifo_rd) rd_seen++;
      if (i >= 11 && bus_if.bit_valid) valid_seen++;
    end
    check("no_rd_while_empty", rd_seen, 0);
`ifndef WS_UNDERRUN_BLANK_EN
    check("stall_no_valid", valid_seen, 0);
`endif
    check("underrun_set", underrun, 1);
    @(negedge clk);
    #1 force_empty = 1'b0;
    wait_frame_done();
    finish_frame(3);
    wr_ptr = rd_ptr;
    check("underrun_sticky", underrun, 1);

    // run drops during strip 0
    load_frame(8'hC3);
    start_run();
    #1 run = 1'b0;
    repeat (5) @(negedge clk);
    check("still_strip0", strip_sel, 0);
    wait_frame_done();
    @(negedge clk);
    check("busy_after_run_drop", busy, 0);
    check("frame_count_run_drop", fd_count, 4);
    rd_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.fifo_rd) rd_seen++;
    end
    check("no_rd_after_stop", rd_seen, 0);

    // Reset in the middle of a byte
    load_frame(8'h99);
    base = hs_count;
    start_run();
    n = 0;
    while (hs_count < base + 11 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("midbyte_timeout", (n >= 500), 0);
    #1 rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    #1 rst_n = 1'b1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("idle_after_reset", busy, 0);
    load_frame(8'h3C);
    start_run();
    #1 run = 1'b0;
    wait_frame_done();
    @(negedge clk);
    check("busy_after_rerun", busy, 0);
    check("frame_count_final", fd_count, 5);
    check("underrun_cleared", underrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
